// File: rtl/lsu_pkg.sv
// Shared types for the RV32I load/store unit: funct3 codes, FSM state and the request legality check.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_ISSUE,
      S_LOAD_WAIT,
      S_STORE_ISSUE,
      S_RESP
   } lsu_state_t;

   // Returns 1 when a request must be answered with an error and no memory access:
   // an unknown funct3 for its direction, or an access not aligned to its size.
   function automatic logic lsu_req_bad(input logic       is_store,
                                        input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
      logic illegal;
      logic misaligned;
      if (is_store) begin
         illegal = funct3[2] || (funct3 == 3'b011);
      end else begin
         illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      // funct3[1:0] encodes the size for both loads and stores: 01 half, 10 word.
      misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                   ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
      return illegal || misaligned;
   endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Load lane extraction: picks the byte/half selected by addr_lo from a RAM word and sign/zero-extends it.
// Latency: combinational.
// Backpressure: none.
// Ports: word (RAM read word), addr_lo (byte offset), funct3 (load type), result (extended value).
module load_align
   import lsu_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   output logic [31:0] result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (addr_lo)
         2'd0:    byte_sel = word[7:0];
         2'd1:    byte_sel = word[15:8];
         2'd2:    byte_sel = word[23:16];
         default: byte_sel = word[31:24];
      endcase
      half_sel = addr_lo[1] ? word[31:16] : word[15:0];

      case (funct3)
         F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   result = {24'd0, byte_sel};
         F3_H:    result = {{16{half_sel[15]}}, half_sel};
         F3_HU:   result = {16'd0, half_sel};
         default: result = word;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store initiator driving a byte-lane word RAM; one request in flight at a time.
// Latency: accept -> resp_valid in 3 cycles (load), 2 (store), 1 (error); no response backpressure.
// Backpressure: o_req_ready only in IDLE; clk_en=0 freezes all state and outputs.
// Ports: clk/rst/clk_en; i_req_* request (valid/ready); o_resp_* completion pulse;
//        o_mem_read_* / i_mem_read_data RAM read port; o_mem_write_* / o_mem_byte_enable RAM write port.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_WIDTH = 29
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clk_en,
   input  logic                  i_req_valid,
   output logic                  o_req_ready,
   input  logic                  i_req_is_store,
   input  logic [2:0]            i_req_funct3,
   input  logic [31:0]           i_req_addr,
   input  logic [31:0]           i_req_wdata,
   output logic                  o_resp_valid,
   output logic                  o_resp_err,
   output logic [31:0]           o_resp_rdata,
   output logic                  o_mem_read_req,
   output logic [ADDR_WIDTH:0]   o_mem_read_addr,
   input  logic [31:0]           i_mem_read_data,
   output logic                  o_mem_write_enable,
   output logic [3:0]            o_mem_byte_enable,
   output logic [ADDR_WIDTH:0]   o_mem_write_addr,
   output logic [31:0]           o_mem_write_data
);

   lsu_state_t          state_q, state_d;
   logic [ADDR_WIDTH:0] waddr_q, waddr_d;
   logic [1:0]          lo_q, lo_d;
   logic [2:0]          f3_q, f3_d;
   logic [3:0]          be_q, be_d;
   logic [31:0]         wdat_q, wdat_d;
   logic                err_q, err_d;
   logic [31:0]         rdata_q, rdata_d;
   logic [31:0]         load_result;

   load_align u_align (
      .word    (i_mem_read_data),
      .addr_lo (lo_q),
      .funct3  (f3_q),
      .result  (load_result)
   );

   always_comb begin
      state_d = state_q;
      waddr_d = waddr_q;
      lo_d    = lo_q;
      f3_d    = f3_q;
      be_d    = be_q;
      wdat_d  = wdat_q;
      err_d   = err_q;
      rdata_d = rdata_q;

      case (state_q)
         S_IDLE: begin
            if (i_req_valid) begin
               // Everything the later states need is captured here, so the request
               // inputs are free to change once the request is accepted.
               waddr_d = i_req_addr[ADDR_WIDTH+2:2];
               lo_d    = i_req_addr[1:0];
               f3_d    = i_req_funct3;
               rdata_d = 32'd0;
               case (i_req_funct3)
                  F3_B: begin
                     be_d   = 4'b0001 << i_req_addr[1:0];
                     wdat_d = {4{i_req_wdata[7:0]}};
                  end
                  F3_H: begin
                     be_d   = 4'b0011 << {i_req_addr[1], 1'b0};
                     wdat_d = {2{i_req_wdata[15:0]}};
                  end
                  default: begin
                     be_d   = 4'b1111;
                     wdat_d = i_req_wdata;
                  end
               endcase
               if (lsu_req_bad(i_req_is_store, i_req_funct3, i_req_addr[1:0])) begin
                  err_d   = 1'b1;
                  state_d = S_RESP;
               end else begin
                  err_d   = 1'b0;
                  state_d = i_req_is_store ? S_STORE_ISSUE : S_LOAD_ISSUE;
               end
            end
         end
         S_LOAD_ISSUE:  state_d = S_LOAD_WAIT;
         S_LOAD_WAIT: begin
            rdata_d = load_result;
            state_d = S_RESP;
         end
         S_STORE_ISSUE: state_d = S_RESP;
         S_RESP:        state_d = S_IDLE;
         default:       state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else if (clk_en) begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         waddr_q <= '0;
         lo_q    <= 2'd0;
         f3_q    <= 3'd0;
         be_q    <= 4'd0;
         wdat_q  <= 32'd0;
         err_q   <= 1'b0;
         rdata_q <= 32'd0;
      end else if (clk_en) begin
         waddr_q <= waddr_d;
         lo_q    <= lo_d;
         f3_q    <= f3_d;
         be_q    <= be_d;
         wdat_q  <= wdat_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   // Strobes decode straight from the state register, so they can never overlap
   // and vanish on the same edge that resets the FSM.
   assign o_req_ready        = (state_q == S_IDLE);
   assign o_mem_read_req     = (state_q == S_LOAD_ISSUE);
   assign o_mem_write_enable = (state_q == S_STORE_ISSUE);
   assign o_resp_valid       = (state_q == S_RESP);
   assign o_resp_err         = err_q;
   assign o_resp_rdata       = rdata_q;
   assign o_mem_read_addr    = waddr_q;
   assign o_mem_write_addr   = waddr_q;
   assign o_mem_byte_enable  = be_q;
   assign o_mem_write_data   = wdat_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural byte-lane RAM.
// Latency: n/a.
// Backpressure: driver waits on o_req_ready; monitor consumes every response.
module tb_load_store_unit;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clk_en = 1'b1;
   logic        i_req_valid = 1'b0;
   logic        o_req_ready;
   logic        i_req_is_store = 1'b0;
   logic [2:0]  i_req_funct3 = 3'd0;
   logic [31:0] i_req_addr = 32'd0;
   logic [31:0] i_req_wdata = 32'd0;
   logic        o_resp_valid;
   logic        o_resp_err;
   logic [31:0] o_resp_rdata;
   logic        o_mem_read_req;
   logic [29:0] o_mem_read_addr;
   logic [31:0] ram_rdata;
   logic        o_mem_write_enable;
   logic [3:0]  o_mem_byte_enable;
   logic [29:0] o_mem_write_addr;
   logic [31:0] o_mem_write_data;

   load_store_unit #(.ADDR_WIDTH(29)) dut (
      .clk                (clk),
      .rst                (rst),
      .clk_en             (clk_en),
      .i_req_valid        (i_req_valid),
      .o_req_ready        (o_req_ready),
      .i_req_is_store     (i_req_is_store),
      .i_req_funct3       (i_req_funct3),
      .i_req_addr         (i_req_addr),
      .i_req_wdata        (i_req_wdata),
      .o_resp_valid       (o_resp_valid),
      .o_resp_err         (o_resp_err),
      .o_resp_rdata       (o_resp_rdata),
      .o_mem_read_req     (o_mem_read_req),
      .o_mem_read_addr    (o_mem_read_addr),
      .i_mem_read_data    (ram_rdata),
      .o_mem_write_enable (o_mem_write_enable),
      .o_mem_byte_enable  (o_mem_byte_enable),
      .o_mem_write_addr   (o_mem_write_addr),
      .o_mem_write_data   (o_mem_write_data)
   );

   always #5 clk = ~clk;

   // Byte-lane RAM with registered read data.
   logic [31:0] mem [0:63];
   always @(posedge clk) begin
      if (o_mem_read_req) ram_rdata <= mem[o_mem_read_addr[5:0]];
      if (o_mem_write_enable)
         for (int i = 0; i < 4; i++)
            if (o_mem_byte_enable[i])
               mem[o_mem_write_addr[5:0]][8*i +: 8] <= o_mem_write_data[8*i +: 8];
   end

   typedef struct packed { logic err; logic [31:0] rdata; logic [3:0] lat; } resp_t;
   typedef struct packed { logic [29:0] addr; logic [3:0] be; logic [31:0] data; } wr_t;

   resp_t       resp_q[$];
   wr_t         wr_q[$];
   logic [29:0] rd_q[$];

   int   errors = 0;
   int   checks = 0;
   int   ecnt = 0;
   int   acc_edge = 0;
   logic last_rst = 1'b0;
   logic last_dis = 1'b0;
   logic end_chk = 1'b0;

   // Enabled-edge counter plus what kind of edge just happened.
   always @(posedge clk) begin
      last_rst <= rst;
      last_dis <= !rst && !clk_en;
      if (rst)         ecnt <= 0;
      else if (clk_en) ecnt <= ecnt + 1;
   end

   logic [132:0] cur_o;
   assign cur_o = {o_req_ready, o_mem_read_req, o_mem_read_addr, o_mem_write_enable,
                   o_mem_byte_enable, o_mem_write_addr, o_mem_write_data,
                   o_resp_valid, o_resp_err, o_resp_rdata};

   // Monitor: the only process that compares and counts.
   always @(negedge clk) begin
      resp_t        r;
      wr_t          w;
      logic [29:0]  ra;
      logic [132:0] snap;
      logic         done;
      int           lat;

      checks++;
      if (o_mem_read_req && o_mem_write_enable) begin
         errors++;
         $display("FAIL strobe_excl: read_req=%0b write_enable=%0b, want not both", o_mem_read_req, o_mem_write_enable);
      end

      if (last_rst) begin
         checks += 2;
         if (o_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %0b want 1", o_req_ready);
         end
         if (cur_o[131:0] !== 132'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", cur_o[131:0]);
         end
      end

      if (last_dis) begin
         checks++;
         if (cur_o !== snap) begin
            errors++;
            $display("FAIL freeze: outputs %h want held %h", cur_o, snap);
         end
      end
      snap = cur_o;

      if (o_mem_read_req && clk_en) begin
         checks++;
         if (rd_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_read: addr %h want no read", o_mem_read_addr);
         end else begin
            ra = rd_q.pop_front();
            if (o_mem_read_addr !== ra) begin
               errors++;
               $display("FAIL read_addr: got %h want %h", o_mem_read_addr, ra);
            end
         end
      end

      if (o_mem_write_enable && clk_en) begin
         checks++;
         if (wr_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: addr %h want no write", o_mem_write_addr);
         end else begin
            w = wr_q.pop_front();
            if ({o_mem_write_addr, o_mem_byte_enable, o_mem_write_data} !== w) begin
               errors++;
               $display("FAIL write: got addr=%h be=%b data=%h want addr=%h be=%b data=%h",
                        o_mem_write_addr, o_mem_byte_enable, o_mem_write_data, w.addr, w.be, w.data);
            end
         end
      end

      if (o_resp_valid && clk_en) begin
         checks++;
         if (resp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_resp: err=%0b rdata=%h want no response", o_resp_err, o_resp_rdata);
         end else begin
            r = resp_q.pop_front();
            lat = ecnt - acc_edge + 1;
            checks += 2;
            if (o_resp_err !== r.err) begin
               errors++;
               $display("FAIL resp_err: got %0b want %0b", o_resp_err, r.err);
            end
            if (o_resp_rdata !== r.rdata) begin
               errors++;
               $display("FAIL resp_rdata: got %h want %h", o_resp_rdata, r.rdata);
            end
            if (lat != int'(r.lat)) begin
               errors++;
               $display("FAIL latency: got %0d want %0d", lat, r.lat);
            end
         end
      end

      if (end_chk && !done) begin
         done = 1'b1;
         checks++;
         if (resp_q.size() + wr_q.size() + rd_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: resp=%0d wr=%0d rd=%0d want 0", resp_q.size(), wr_q.size(), rd_q.size());
         end
      end
   end

   // mode: 0 normal, 1 freeze clk_en for 5 cycles in LOAD_WAIT, 2 reset during STORE_ISSUE.
   task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic exp_err, input logic [31:0] exp_rd,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd, input int mode);
      resp_t r;
      wr_t   w;
      int    n;
      r.err   = exp_err;
      r.rdata = exp_rd;
      r.lat   = exp_err ? 4'd1 : (st ? 4'd2 : 4'd3);
      if (mode != 2) resp_q.push_back(r);
      if (!exp_err) begin
         if (st) begin
            w.addr = addr[31:2];
            w.be   = exp_be;
            w.data = exp_wd;
            wr_q.push_back(w);
         end else begin
            rd_q.push_back(addr[31:2]);
         end
      end

      @(negedge clk);
      i_req_valid    = 1'b1;
      i_req_is_store = st;
      i_req_funct3   = f3;
      i_req_addr     = addr;
      i_req_wdata    = wd;
      n = 0;
      while (!(o_req_ready && clk_en)) begin
         @(negedge clk);
         n++;
         if (n > 20) begin
            $display("FAIL accept_timeout: ready=%0b want 1 within 20 cycles", o_req_ready);
            $fatal(1);
         end
      end
      @(posedge clk);
      #1;
      acc_edge       = ecnt;
      i_req_valid    = 1'b0;
      i_req_is_store = ~st;
      i_req_funct3   = 3'($urandom);
      i_req_addr     = $urandom;
      i_req_wdata    = $urandom;

      if (mode == 1) begin
         @(posedge clk);
         #1;
         clk_en = 1'b0;
         repeat (5) @(posedge clk);
         #1;
         clk_en = 1'b1;
      end else if (mode == 2) begin
         rst = 1'b1;
         @(posedge clk);
         #1;
         rst = 1'b0;
      end

      n = 0;
      while (resp_q.size() + wr_q.size() + rd_q.size() != 0) begin
         @(negedge clk);
         n++;
         if (n > 50) begin
            $display("FAIL completion_timeout: %0d items outstanding want 0", resp_q.size() + wr_q.size() + rd_q.size());
            $fatal(1);
         end
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);

      //     st  f3      addr          wdata         err  exp_rdata     be       exp_wdata     mode
      issue(1, F3_W,   32'h10, 32'hDEADBEEF, 0, 32'h0,        4'b1111, 32'hDEADBEEF, 0);
      issue(0, F3_W,   32'h10, 32'h0,        0, 32'hDEADBEEF, 4'b0000, 32'h0,        0);
      issue(1, F3_W,   32'h10, 32'h80FF7F01, 0, 32'h0,        4'b1111, 32'h80FF7F01, 0);
      issue(0, F3_B,   32'h13, 32'h0,        0, 32'hFFFFFF80, 4'b0000, 32'h0,        0);
      issue(0, F3_BU,  32'h13, 32'h0,        0, 32'h00000080, 4'b0000, 32'h0,        0);
      issue(0, F3_H,   32'h12, 32'h0,        0, 32'hFFFF80FF, 4'b0000, 32'h0,        0);
      issue(0, F3_HU,  32'h10, 32'h0,        0, 32'h00007F01, 4'b0000, 32'h0,        0);
      issue(0, F3_B,   32'h11, 32'h0,        0, 32'h0000007F, 4'b0000, 32'h0,        0);
      issue(1, F3_W,   32'h20, 32'h11223344, 0, 32'h0,        4'b1111, 32'h11223344, 0);
      issue(1, F3_B,   32'h21, 32'h123456AB, 0, 32'h0,        4'b0010, 32'hABABABAB, 0);
      issue(1, F3_H,   32'h22, 32'h0000CAFE, 0, 32'h0,        4'b1100, 32'hCAFECAFE, 0);
      issue(0, F3_W,   32'h20, 32'h0,        0, 32'hCAFEAB44, 4'b0000, 32'h0,        0);
      issue(0, F3_W,   32'h02, 32'h0,        1, 32'h0,        4'b0000, 32'h0,        0);
      issue(1, F3_H,   32'h05, 32'h1234,     1, 32'h0,        4'b0000, 32'h0,        0);
      issue(0, 3'b011, 32'h10, 32'h0,        1, 32'h0,        4'b0000, 32'h0,        0);
      issue(1, F3_BU,  32'h10, 32'h0,        1, 32'h0,        4'b0000, 32'h0,        0);
      issue(0, F3_H,   32'h11, 32'h0,        1, 32'h0,        4'b0000, 32'h0,        0);
      issue(0, F3_HU,  32'h22, 32'h0,        0, 32'h0000CAFE, 4'b0000, 32'h0,        1);
      issue(1, F3_B,   32'h30, 32'h00000055, 0, 32'h0,        4'b0001, 32'h55555555, 2);
      issue(0, F3_W,   32'h10, 32'h0,        0, 32'h80FF7F01, 4'b0000, 32'h0,        0);
      issue(0, F3_H,   32'h20, 32'h0,        0, 32'hFFFFAB44, 4'b0000, 32'h0,        0);

      repeat (3) @(negedge clk);
      end_chk = 1'b1;
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
RV32I load/store initiator that drives the byte-lane word RAM's read/write port from the core's memory stage. It accepts one load or store at a time over a valid/ready handshake and emits byte enables and lane-replicated store data. For loads it issues a one-cycle read request, captures the registered RAM data, then lane-extracts and sign/zero-extends it. It returns a one-cycle response pulse carrying load data or an error flag.

Parameters:
ADDR_WIDTH, 29, MSB index of the word address driven to the RAM; word addr = byte addr[ADDR_WIDTH+2:2]; legal range 0..29.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
clk_en  in  1  global advance enable; all state/outputs hold when 0 (except reset)
i_req_valid  in  1  request present
o_req_ready  out  1  high only in IDLE; request accepted on clk edge with valid&ready&clk_en
i_req_is_store  in  1  1=store, 0=load
i_req_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
i_req_addr  in  32  byte address
i_req_wdata  in  32  store source (rs2)
o_resp_valid  out  1  one-cycle completion pulse
o_resp_err  out  1  qualified by o_resp_valid; misaligned or illegal funct3
o_resp_rdata  out  32  load result, qualified by o_resp_valid&!o_resp_err; 0 for stores/errors
o_mem_read_req  out  1  RAM read request
o_mem_read_addr  out  ADDR_WIDTH+1  RAM word read address
i_mem_read_data  in  32  RAM read data, valid the cycle after read_req is sampled
o_mem_write_enable  out  1  RAM write strobe
o_mem_byte_enable  out  4  lane enables, bit n = bits[8n+7:8n]
o_mem_write_addr  out  ADDR_WIDTH+1  RAM word write address
o_mem_write_data  out  32  lane-replicated store data

Behaviour:
- Single clock, synchronous active-high reset. rst takes priority over clk_en. Reset: state=IDLE; every registered output = 0; o_req_ready=1 (combinational from state).
- Reset mid-operation aborts silently: no response pulse. A write strobe already presented at the reset edge may still be committed by the RAM.
- FSM states: IDLE, LOAD_ISSUE, LOAD_WAIT, STORE_ISSUE, RESP. Transitions occur only on edges with clk_en=1.
- IDLE + accept:
  - Illegal funct3 (load 011/110/111; store 1xx/011) or misaligned (H with addr[0]=1; W with addr[1:0]!=0) -> RESP with err=1. No memory access.
  - Legal load -> LOAD_ISSUE.
  - Legal store -> STORE_ISSUE.
- LOAD_ISSUE: read_req=1, read_addr=word addr (registered at accept). Next state LOAD_WAIT.
- LOAD_WAIT: i_mem_read_data valid.
  - Extract by latched addr[1:0]. LB/LBU use lane addr[1:0]; LH/LHU use lanes {2a+1,2a} with a=addr[1].
  - Sign-extend LB/LH, zero-extend LBU/LHU, LW passes through.
  - Register the result into o_resp_rdata. Next state RESP.
- STORE_ISSUE: write_enable=1 for exactly one cycle.
  - byte_enable: SB = 0001<<addr[1:0]; SH = 0011<<{addr[1],1'b0}; SW = 1111.
  - write_data: SB = {4{wdata[7:0]}}; SH = {2{wdata[15:0]}}; SW = wdata.
  - Next state RESP.
- RESP: o_resp_valid=1 for one cycle, then IDLE. There is no response backpressure.
- Latency from accept edge to o_resp_valid high: load 3 cycles, store 2, error 1. Back-to-back throughput: one request per latency+1 cycles.
- read_req and write_enable are never high in the same cycle. Both are 0 outside their ISSUE state. Addresses and data are don't-care when their strobes are low.
- clk_en=0 in any state freezes state and all outputs, including a pending strobe or resp pulse, which stays asserted until the next enabled edge.
- The request inputs are sampled only at the accept edge; later changes are ignored.

Decomposition:
- lsu_pkg holds:
  - funct3 localparams F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101;
  - the state enum lsu_state_t;
  - a helper function for the misalign/illegal check.
- One combinational sub-module, load_align (inputs: word, addr[1:0], funct3; output: 32-bit extended result), instantiated in LOAD_WAIT's datapath.

Test Plan:
- After reset with clk_en=1: o_req_ready=1 and all other outputs 0. Issue SW addr=0x10, wdata=0xDEADBEEF -> next cycle write_enable=1, be=1111, write_addr=4, write_data=0xDEADBEEF. The cycle after that, resp_valid=1, err=0.
- Preload word 4 = 0x80FF7F01. LB addr=0x13 -> read_req one cycle with read_addr=4. resp_valid 3 cycles after accept, rdata=0xFFFFFF80. LBU addr=0x13 -> 0x00000080. LH addr=0x12 -> 0xFFFF80FF. LHU addr=0x10 -> 0x00007F01.
- SB addr=0x21, wdata=0x123456AB -> be=0010, write_data=0xABABABAB. SH addr=0x22, wdata=0x0000CAFE -> be=1100, write_data=0xCAFECAFE. Read back the word after both stores -> 0xCAFEABxx, with lanes 0 and 1's low byte unchanged.
- LW addr=0x02 and SH addr=0x05 -> resp_valid 1 cycle after accept with err=1. No read_req or write_enable pulse. funct3=3'b011 load -> err=1.
- Hold clk_en=0 for 5 cycles during LOAD_WAIT -> state and outputs frozen. After clk_en returns to 1, exactly one resp_valid with correct data.
- Assert rst during STORE_ISSUE -> next cycle all outputs 0, ready=1, no resp_valid. A new LW then completes normally.
